// File: rtl/sodor_dmem_scratchpad_bridge.sv
// ============================================================================
// Module      : sodor_dmem_scratchpad_bridge
// Description : Core dmem slave driving a fixed-latency 32-bit SRAM macro with
//               byte enables, lane replication and load sign/zero extension.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sodor_dmem_scratchpad_bridge #(
    parameter int ADDR_W  = 10,
    parameter int MEM_LAT = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              io_dmem_req_valid,
    input  logic [31:0]       io_dmem_req_bits_addr,
    input  logic [31:0]       io_dmem_req_bits_data,
    input  logic              io_dmem_req_bits_fcn,
    input  logic [2:0]        io_dmem_req_bits_typ,
    output logic              io_dmem_resp_valid,
    output logic [31:0]       io_dmem_resp_bits_data,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [2:0] C_LAST = 3'(MEM_LAT - 1);

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [2:0]  typ_q, typ_d;
    logic [1:0]  off_q, off_d;
    logic        fcn_q, fcn_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_data_q, resp_data_d;

    logic        w_accept;
    logic [1:0]  w_off;
    logic [31:0] w_shift_b;
    logic [31:0] w_shift_h;
    logic [31:0] w_load;
    logic        w_unused_addr;

    assign w_unused_addr = ^io_dmem_req_bits_addr[31:ADDR_W+2];
    assign w_off         = io_dmem_req_bits_addr[1:0];

    // Gating on reset keeps the SRAM quiet while the bridge is held in reset.
    assign w_accept = (state_q == ST_IDLE) && io_dmem_req_valid && reset;
    assign mem_en   = w_accept;
    assign mem_we   = w_accept && io_dmem_req_bits_fcn;
    assign mem_addr = io_dmem_req_bits_addr[ADDR_W+1:2];

    always_comb begin
        mem_be    = 4'b0000;
        mem_wdata = io_dmem_req_bits_data;
        case (io_dmem_req_bits_typ[1:0])
            2'b01: begin
                mem_wdata = {4{io_dmem_req_bits_data[7:0]}};
                if (mem_we) mem_be = 4'b0001 << w_off;
            end
            2'b10: begin
                mem_wdata = {2{io_dmem_req_bits_data[15:0]}};
                if (mem_we) mem_be = w_off[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                if (mem_we) mem_be = 4'b1111;
            end
        endcase
    end

    // Halfword lane only follows off[1], so a misaligned half at offset 3 reads bytes 3:2.
    assign w_shift_b = mem_rdata >> {off_q, 3'b000};
    assign w_shift_h = mem_rdata >> {off_q[1], 4'b0000};

    always_comb begin
        case (typ_q)
            3'd1:    w_load = {{24{w_shift_b[7]}}, w_shift_b[7:0]};
            3'd5:    w_load = {24'd0, w_shift_b[7:0]};
            3'd2:    w_load = {{16{w_shift_h[15]}}, w_shift_h[15:0]};
            3'd6:    w_load = {16'd0, w_shift_h[15:0]};
            default: w_load = mem_rdata;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        typ_d        = typ_q;
        off_d        = off_q;
        fcn_d        = fcn_q;
        resp_valid_d = 1'b0;
        resp_data_d  = resp_data_q;
        case (state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    typ_d   = io_dmem_req_bits_typ;
                    off_d   = w_off;
                    fcn_d   = io_dmem_req_bits_fcn;
                    cnt_d   = 3'd0;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == C_LAST) begin
                    resp_data_d  = fcn_q ? 32'd0 : w_load;
                    resp_valid_d = 1'b1;
                    state_d      = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 3'd0;
            typ_q        <= 3'd0;
            off_q        <= 2'd0;
            fcn_q        <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= 32'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            typ_q        <= typ_d;
            off_q        <= off_d;
            fcn_q        <= fcn_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
        end
    end

    assign io_dmem_resp_valid     = resp_valid_q;
    assign io_dmem_resp_bits_data = resp_data_q;

endmodule

`default_nettype wire
